mux_sel_scheduler: RTL
======================

Name: mux_sel_scheduler

Overview:
Round-robin select sequencer that drives the s1/s0 select pair of the 4:1 mux (mux4to1) directly downstream. It arbitrates among four channel requests and holds each grant for a programmable dwell time. It also produces a valid qualifier for the mux output y.

Parameters:
DWELL, 4, cycles each grant is held; legal range 1..255
CW, 8, dwell counter width; must satisfy 2^CW > DWELL

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
en  input  1  scheduler enable
req  input  4  per-channel request; req[i] maps to mux input wi
s0  output  1  mux select LSB
s1  output  1  mux select MSB
gnt  output  4  one-hot grant, equal to decode of {s1,s0} while valid=1, else 4'b0000
valid  output  1  high while a grant is active; qualifies y
done  output  1  high during the last cycle of a grant

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: s0=0, s1=0, gnt=0000, valid=0, done=0, internal counter cnt=0, last-grant pointer ptr=3, state=IDLE. These take effect immediately on rst assertion, including mid-grant.
- All outputs are registered, except done, which is decoded from registered state: done = valid & (cnt==0).
- FSM states are IDLE and GRANT.
- Arbitration: search order is ptr+1, ptr+2, ptr+3, ptr, all mod 4. The first index with req=1 wins.
  - After reset, ptr=3, so channel 0 has highest priority.
  - On each new grant, ptr is set to the winning index.
- IDLE:
  - If en=1 and req!=0, arbitrate. At the next edge: {s1,s0}=winner, gnt=onehot(winner), valid=1, cnt=DWELL-1, state=GRANT.
  - Latency from request to grant is 1 cycle.
  - Otherwise stay in IDLE with valid=0 and gnt=0. s1/s0 hold their last value so the mux output stays stable.
- GRANT, normal:
  - cnt decrements by 1 each cycle while cnt>0.
  - When cnt==0 (done=1) and en=1 and req!=0: re-arbitrate and load the new grant at the next edge with no idle gap. The same channel may win again if it is the only requester.
  - When cnt==0 and (en=0 or req==0): go to IDLE at the next edge with valid=0 and gnt=0.
- GRANT, early release:
  - If req[current] drops while cnt>0, the grant ends at the next edge.
  - Re-arbitration happens in that same cycle, using the same rules as cnt==0.
  - done is not asserted for an early-terminated grant.
- en=0 mid-dwell: the current grant runs to completion (cnt reaches 0, done pulses), then the block goes to IDLE. en has no effect on a grant already in progress.
- Simultaneous cases:
  - A req rise on the current channel at cnt==0 follows normal arbitration.
  - A req drop on the current channel at cnt==0 is treated as normal end of grant, with done=1.
- DWELL=1: every grant lasts one cycle and done=valid.
- Counter wrap: cnt never underflows. It is only reloaded on a new grant.

Test Plan:
1. DWELL=4. rst=1, then release; hold en=1, req=1111 -> first grant one cycle after release: {s1,s0}=00, gnt=0001. Grants then run 01, 10, 11, 00, each valid for exactly 4 cycles with no gaps. done is high in cycles 4, 8, 12, ...
2. en=1, req=0100 constant -> gnt=0100 and {s1,s0}=10 continuously. valid never drops. done pulses every 4 cycles.
3. Grant on ch1 (req=0010). Drop req[1] after 2 grant cycles while req[3]=1 -> at the next edge gnt=1000 and {s1,s0}=11. No done pulse for ch1.
4. Grant on ch0 with req=0001. Set en=0 at grant cycle 2 -> grant continues to cycle 4 with done=1, then valid=0, gnt=0000, and {s1,s0} holds 00.
5. Assert rst asynchronously between clock edges during a grant on ch2 -> valid, gnt, done, s1 and s0 are all 0 immediately. After release with req=0110, the first grant goes to ch1 (ptr reset to 3).
6. en=1, req=0000 for 10 cycles -> stays IDLE with valid=0 and gnt=0000. Setting req=1000 -> gnt=1000 one cycle later.

Source files
------------

// File: rtl/mux_sel_scheduler.sv
// Round-robin select sequencer for the downstream 4:1 mux; holds each grant for DWELL cycles.
// Latency: request to grant 1 cycle; back-to-back grants with no idle gap when requests remain.
// Backpressure: none; a grant ends early when its own request drops, en only gates new grants.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         scheduler enable (gates new grants only)
//   req[3:0]   per-channel request, req[i] -> mux input wi
//   s1, s0     mux select pair (held while idle so the mux output stays stable)
//   gnt[3:0]   one-hot grant, zero while not valid
//   valid      grant active, qualifies mux output y
//   done       last cycle of a grant that ran its full dwell
module mux_sel_scheduler #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic       s0,
    output logic       s1,
    output logic [3:0] gnt,
    output logic       valid,
    output logic       done
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [1:0]    r_sel;
    logic [1:0]    r_ptr;
    logic [3:0]    r_gnt;
    logic          r_valid;
    logic [CW-1:0] r_cnt;

    logic [1:0]    w_win;
    logic          w_any;
    logic          w_end;
    logic          w_load;

    // Round-robin pick: scanning from the lowest priority (ptr itself) up to
    // ptr+1 lets the last hit be the highest-priority requester.
    always_comb begin
        w_win = r_ptr;
        for (int k = 4; k >= 1; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_win = r_ptr + 2'(k);
            end
        end
    end

    assign w_any  = |req;
    // A grant ends either on dwell expiry or when its own request drops.
    assign w_end  = (r_state == GRANT) && ((r_cnt == '0) || !req[r_sel]);
    assign w_load = en && w_any && ((r_state == IDLE) || w_end);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (w_end) begin
                    w_state_nxt = w_load ? GRANT : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Registered grant datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel   <= 2'd0;
            r_ptr   <= 2'd3;
            r_gnt   <= 4'b0000;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_load) begin
                r_sel   <= w_win;
                r_ptr   <= w_win;
                r_gnt   <= 4'b0001 << w_win;
                r_valid <= 1'b1;
                r_cnt   <= CW'(DWELL - 1);
            end else if (w_end) begin
                // Select is deliberately left untouched while idle.
                r_valid <= 1'b0;
                r_gnt   <= 4'b0000;
            end else if ((r_state == GRANT) && (r_cnt != '0)) begin
                r_cnt   <= r_cnt - 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        s0    = r_sel[0];
        s1    = r_sel[1];
        gnt   = r_gnt;
        valid = r_valid;
        done  = r_valid && (r_cnt == '0);
    end

endmodule
